tc_period_meter: RTL and testbench
==================================

// Module: tc_period_meter
// PURPOSE
//  Receive-side monitor for the cascaded-counter chain. Takes the final terminal-count (tc) line
//  of the chain and measures the clk cycles between consecutive tc rising edges.
//  Latches each period and checks it against an expected value within a tolerance.
//  Keeps a pulse tally and reports each measurement with a one-cycle valid strobe for LED/debug logic.
//  Sits beside the counter chain in the top level, in the same clock domain.
// PARAMETERS
//  CNT_W   32    width of the period counter and of the period output
//  EXPECT  1000  expected tc-to-tc period in clk cycles
//  TOL     0     allowed |period-EXPECT| deviation for in_range
// PORTS
//  clk          in   1      system clock (MAX10_CLK1_50 at top level); all logic on posedge
//  reset_n      in   1      asynchronous, active-low reset
//  enable       in   1      measurement enable (level)
//  tc_in        in   1      terminal count from the last counter in the chain; synchronous to clk
//  period       out  CNT_W  last measured rise-to-rise period, in clk cycles
//  period_valid out  1      one-cycle strobe: period/in_range were updated this cycle
//  in_range     out  1      registered with period: |period-EXPECT| <= TOL
//  pulse_count  out  16     number of tc rising edges seen while enabled; wraps 0xFFFF->0
//  overflow     out  1      sticky: a gap exceeded 2^CNT_W-1 cycles
//  busy         out  1      high in MEASURE state
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): all outputs 0, cnt=0, tc_q=0, state=IDLE.
//  - Edge detect: tc_q <= tc_in every cycle; rise = tc_in & ~tc_q.
//    A tc held high counts as one rise.
//  - States:
//    IDLE:    enable=1 -> ARMED.
//    ARMED:   rise -> cnt<=1, go to MEASURE. pulse_count increments.
//    MEASURE: no rise and cnt<max -> cnt<=cnt+1.
//             rise -> period<=cnt, in_range updated, period_valid=1 next cycle, cnt<=1,
//             pulse_count++, stay in MEASURE.
//             no rise and cnt==2^CNT_W-1 -> overflow<=1, cnt<=0, go to ARMED
//             (partial gap is discarded; period is not updated).
//  - enable=0 in any state -> IDLE next edge; cnt<=0. period, in_range, pulse_count and overflow hold.
//    period_valid=0. Takes priority over a simultaneous rise, which is ignored.
//  - Priorities: a rise with cnt==max latches period=max, with no overflow.
//    enable=0 beats a rise, and a rise beats overflow.
//  - Latency: the rise is sampled at edge k; period/in_range/period_valid are valid after edge k.
//    period_valid is high for exactly one cycle.
//  - Period definition: rises at edges k and k+N -> period=N (N>=1; back-to-back rises need a low cycle, so N>=2).
//  - in_range arithmetic: signed CNT_W+1-bit difference period-EXPECT, then absolute value
//    compared to TOL. No truncation.
//  - overflow clears only on reset_n. busy = (state==MEASURE).
// TESTING
//  T1: enable=1, 1-cycle tc pulses every 10 clks, EXPECT=10, TOL=0
//      -> first valid after the 2nd pulse: period=10, in_range=1; pulse_count=1,2,3...
//  T2: periods 9, 10, 12 with EXPECT=10, TOL=1 -> in_range 1, 1, 0.
//      period_valid high for one cycle per pulse.
//  T3: CNT_W=8, one pulse, then a 300-clk gap -> overflow=1 at cnt 255, state ARMED.
//      Next two pulses 5 apart -> period=5.
//  T4: enable low mid-MEASURE (cnt=4) while tc pulses -> no valid; period holds.
//      Re-enable -> ARMED; first pulse gives no valid.
//  T5: tc held high 20 cycles, then low, then high again 30 cycles after the first rise
//      -> one valid with period=30.
//  T6: reset_n pulsed low asynchronously mid-MEASURE -> outputs 0 immediately.
//      After release + enable -> IDLE->ARMED; overflow=0.

Source files
------------

// File: rtl/tc_period_meter.sv
// Measures clk cycles between consecutive rising edges of the counter chain's
// terminal-count line and flags each period against EXPECT +/- TOL.
module tc_period_meter #(
  parameter int          CNT_W  = 32,
  parameter int unsigned EXPECT = 1000,
  parameter int unsigned TOL    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tc_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic [15:0]      pulse_count,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   EXP_V   = (CNT_W+1)'(EXPECT);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tc_q;
  logic             rise;

  logic signed [CNT_W:0] diff;
  logic        [CNT_W:0] mag;
  logic                  cnt_in_range;

  assign rise = tc_in & ~tc_q;
  assign busy = (state == MEASURE);

  // One extra bit keeps period-EXPECT exact for every cnt/EXPECT pair, so the
  // magnitude never wraps before it is compared with TOL.
  always_comb begin
    diff         = $signed({1'b0, cnt}) - $signed(EXP_V);
    mag          = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    cnt_in_range = (mag <= TOL_V);
  end

  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      tc_q         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      pulse_count  <= '0;
      overflow     <= 1'b0;
    end else begin
      tc_q         <= tc_in;
      period_valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            if (rise) begin
              cnt         <= CNT_W'(1);
              pulse_count <= pulse_count + 16'd1;
              state       <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period       <= cnt;
              in_range     <= cnt_in_range;
              period_valid <= 1'b1;
              cnt          <= CNT_W'(1);
              pulse_count  <= pulse_count + 16'd1;
            end else if (cnt == CNT_MAX) begin
              // Gap too long to represent: drop it and wait for a fresh start edge.
              overflow <= 1'b1;
              cnt      <= '0;
              state    <= ARMED;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tc_period_meter.sv
// Self-checking bench for tc_period_meter: directed vector table, corner-case
// sequences and a randomized stream, all compared against an edge-index model.
module tb_tc_period_meter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         tc_in;
  logic [W-1:0] period, period_hi;
  logic         period_valid, period_valid_hi;
  logic         in_range, in_range_hi;
  logic [15:0]  pulse_count, pulse_count_hi;
  logic         overflow, overflow_hi;
  logic         busy, busy_hi;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tc_period_meter #(.CNT_W(W), .EXPECT(10), .TOL(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tc_in(tc_in),
    .period(period), .period_valid(period_valid), .in_range(in_range),
    .pulse_count(pulse_count), .overflow(overflow), .busy(busy)
  );

  tc_period_meter #(.CNT_W(W), .EXPECT(250), .TOL(5)) dut_hi (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tc_in(tc_in),
    .period(period_hi), .period_valid(period_valid_hi), .in_range(in_range_hi),
    .pulse_count(pulse_count_hi), .overflow(overflow_hi), .busy(busy_hi)
  );

  // Reference model: remembers the edge index of the last accepted rise.
  int          m_edge;
  int          m_last;
  bit          m_has_last;
  bit          m_en_prev;
  bit          m_tc_prev;
  int          m_period;
  bit          m_valid;
  bit          m_inr;
  bit          m_inr_hi;
  logic [15:0] m_pc;
  bit          m_ovf;

  function automatic bit in_tol(input int p, input int e, input int t);
    int d;
    d = p - e;
    if (d < 0) d = -d;
    return d <= t;
  endfunction

  task automatic model_reset();
    m_edge = 0; m_last = 0; m_has_last = 0; m_en_prev = 0; m_tc_prev = 0;
    m_period = 0; m_valid = 0; m_inr = 0; m_inr_hi = 0; m_pc = '0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit en, input bit tc);
    bit rise;
    rise    = tc && !m_tc_prev;
    m_valid = 0;
    if (!en) begin
      m_has_last = 0;
    end else if (m_en_prev) begin
      if (rise) begin
        if (m_has_last) begin
          m_period = m_edge - m_last;
          m_valid  = 1;
          m_inr    = in_tol(m_period, 10, 1);
          m_inr_hi = in_tol(m_period, 250, 5);
        end
        m_pc       = m_pc + 16'd1;
        m_has_last = 1;
        m_last     = m_edge;
      end else if (m_has_last && (m_edge - m_last) == (1 << W) - 1) begin
        m_ovf      = 1;
        m_has_last = 0;
      end
    end
    m_en_prev = en;
    m_tc_prev = tc;
    m_edge++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("period",       32'(period),       32'(m_period));
    check("period_valid", 32'(period_valid), 32'(m_valid));
    check("in_range",     32'(in_range),     32'(m_inr));
    check("pulse_count",  32'(pulse_count),  32'(m_pc));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("busy",         32'(busy),         32'(m_has_last));
    check("period_hi",    32'(period_hi),    32'(m_period));
    check("in_range_hi",  32'(in_range_hi),  32'(m_inr_hi));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"},      32'(period),       0);
    check({tag, "_valid"},       32'(period_valid), 0);
    check({tag, "_in_range"},    32'(in_range),     0);
    check({tag, "_pulse_count"}, 32'(pulse_count),  0);
    check({tag, "_overflow"},    32'(overflow),     0);
    check({tag, "_busy"},        32'(busy),         0);
  endtask

  task automatic step(input bit en, input bit tc);
    @(negedge clk);
    enable = en;
    tc_in  = tc;
    @(posedge clk);
    model_edge(en, tc);
    #1;
    compare_model();
  endtask

  // gap-1 low cycles, then a one-cycle high: rise lands gap edges after the last one.
  task automatic pulse_after(input int gap);
    for (int i = 0; i < gap - 1; i++) step(1, 0);
    step(1, 1);
  endtask

  typedef struct {
    int          gap;
    logic [7:0]  exp_period;
    logic        exp_inr;
    logic        exp_inr_hi;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nvalid;

    vecs[0] = '{10,  8'd10,  1'b1, 1'b0, 16'd2};
    vecs[1] = '{10,  8'd10,  1'b1, 1'b0, 16'd3};
    vecs[2] = '{9,   8'd9,   1'b1, 1'b0, 16'd4};
    vecs[3] = '{12,  8'd12,  1'b0, 1'b0, 16'd5};
    vecs[4] = '{11,  8'd11,  1'b1, 1'b0, 16'd6};
    vecs[5] = '{2,   8'd2,   1'b0, 1'b0, 16'd7};
    vecs[6] = '{8,   8'd8,   1'b0, 1'b0, 16'd8};
    vecs[7] = '{255, 8'd255, 1'b0, 1'b1, 16'd9};
    vecs[8] = '{244, 8'd244, 1'b0, 1'b0, 16'd10};
    vecs[9] = '{245, 8'd245, 1'b0, 1'b1, 16'd11};

    reset_n = 1'b0;
    enable  = 1'b0;
    tc_in   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Arm, then the first rise starts a measurement without a valid.
    step(1, 0);
    check("armed_busy", 32'(busy), 0);
    step(1, 0);
    step(1, 1);
    check("first_valid", 32'(period_valid), 0);
    check("first_pc",    32'(pulse_count),  1);
    check("first_busy",  32'(busy),         1);

    foreach (vecs[i]) begin
      pulse_after(vecs[i].gap);
      check("tbl_valid",    32'(period_valid), 1);
      check("tbl_period",   32'(period),       32'(vecs[i].exp_period));
      check("tbl_in_range", 32'(in_range),     32'(vecs[i].exp_inr));
      check("tbl_inr_hi",   32'(in_range_hi),  32'(vecs[i].exp_inr_hi));
      check("tbl_pc",       32'(pulse_count),  32'(vecs[i].exp_pc));
    end
    step(1, 0);
    check("valid_one_cycle", 32'(period_valid), 0);

    // Overflow: 255 counted cycles without a rise discards the gap.
    for (int i = 0; i < 253; i++) step(1, 0);
    check("pre_ovf", 32'(overflow), 0);
    check("pre_ovf_busy", 32'(busy), 1);
    step(1, 0);
    check("ovf_set",  32'(overflow), 1);
    check("ovf_busy", 32'(busy),     0);
    check("ovf_period_hold", 32'(period), 245);
    for (int i = 0; i < 45; i++) step(1, 0);
    step(1, 1);
    check("post_ovf_first_valid", 32'(period_valid), 0);
    pulse_after(5);
    check("post_ovf_period", 32'(period),   5);
    check("ovf_sticky",      32'(overflow), 1);

    // Disable mid-measurement while tc rises: the rise is ignored.
    step(1, 0); step(1, 0); step(1, 0);
    step(0, 1);
    check("dis_valid",  32'(period_valid), 0);
    check("dis_busy",   32'(busy),         0);
    check("dis_period", 32'(period),       5);
    check("dis_pc",     32'(pulse_count),  13);
    step(0, 0);
    step(1, 0);
    step(1, 1);
    check("reen_valid", 32'(period_valid), 0);
    check("reen_busy",  32'(busy),         1);
    pulse_after(7);
    check("reen_period", 32'(period), 7);

    // tc held high counts once; period runs rise to rise.
    step(1, 0);
    step(1, 1);
    nvalid = 0;
    for (int i = 0; i < 19; i++) begin step(1, 1); nvalid += int'(period_valid); end
    for (int i = 0; i < 10; i++) begin step(1, 0); nvalid += int'(period_valid); end
    check("held_no_valid", 32'(nvalid), 0);
    step(1, 1);
    check("held_period", 32'(period),   30);
    check("held_inr",    32'(in_range), 0);

    // Asynchronous reset mid-measurement.
    step(1, 0); step(1, 0); step(1, 0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    enable = 1'b0;
    tc_in  = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0);
    check("rst_armed_busy", 32'(busy),     0);
    check("rst_ovf",        32'(overflow), 0);
    step(1, 1);
    check("rst_first_pc", 32'(pulse_count), 1);
    pulse_after(10);
    check("rst_period", 32'(period),   10);
    check("rst_inr",    32'(in_range), 1);

    // Randomized stream against the model.
    for (int s = 0; s < 250; s++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        repeat ($urandom_range(1, 4)) step(0, 1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        repeat ($urandom_range(200, 300)) step(1, 0);
      end else begin
        repeat ($urandom_range(1, 3)) step(1, 1);
        repeat ($urandom_range(1, 20)) step(1, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
